// File: rtl/vid_sync_tracker.sv
// vid_sync_tracker: recovers pixel counts from sync/DE, measures timing, tracks lock.
// Define VID_SYNC_TRACKER_DE_CHECK_EN to also drop lock on DE/count disagreement.
module vid_sync_tracker #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNELS      = 3,
  parameter int LOCK_FRAMES   = 2,
  parameter int SYNC_POL      = 1,
  localparam int H_FRAME = H_ACTIVE + H_FRONT_PORCH
                         + H_SYNC_WIDTH + H_BACK_PORCH,
  localparam int V_FRAME = V_ACTIVE + V_FRONT_PORCH
                         + V_SYNC_WIDTH + V_BACK_PORCH,
  localparam int PW = CHANNELS * DATA_WIDTH,
  localparam int HW = $clog2(H_FRAME),
  localparam int VW = $clog2(V_FRAME),
  localparam int LW = $clog2(2 * H_FRAME) + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          in_hsync,
  input  logic          in_vsync,
  input  logic          in_vde,
  input  logic [PW-1:0] in_data,
  output logic [PW-1:0] out_data,
  output logic          out_vde,
  output logic [HW-1:0] out_hcnt,
  output logic [VW-1:0] out_vcnt,
  output logic          out_locked,
  output logic          out_err,
  output logic [15:0]   out_frame_cnt,
  output logic [LW-1:0] out_line_len
);

  localparam int TW = $clog2(V_FRAME + 2) + 1;
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [LW-1:0] L_MAX = '1;
  localparam logic [TW-1:0] T_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_good;
  logic          r_hs;
  logic          r_vs;
  logic          r_hs_d;
  logic          r_vs_d;
  logic          r_de;
  logic [PW-1:0] r_data;
  logic [LW-1:0] r_line_cnt;
  logic [TW-1:0] r_tally;
  logic          r_bad;

  logic          w_hs_in;
  logic          w_vs_in;
  logic          w_hlead;
  logic          w_vlead;
  logic          w_hwrap;
  logic [HW-1:0] w_hcnt_nx;
  logic [VW-1:0] w_vcnt_nx;
  logic          w_len_bad;
  logic          w_timeout;
  logic [TW:0]   w_tally_tot;
  logic          w_tally_ok;
  logic          w_frame_good;
  logic          w_de_bad;

  assign w_hs_in = (SYNC_POL != 0) ? in_hsync : ~in_hsync;
  assign w_vs_in = (SYNC_POL != 0) ? in_vsync : ~in_vsync;
  assign w_hlead = r_hs & ~r_hs_d;
  assign w_vlead = r_vs & ~r_vs_d;

  // Count of the pixel currently in the input register.
  always_comb begin
    w_hwrap   = (out_hcnt == HW'(H_FRAME - 1)) && !w_hlead;
    w_hcnt_nx = out_hcnt + 1'b1;
    w_vcnt_nx = out_vcnt;
    if (w_hwrap) begin
      w_hcnt_nx = '0;
      w_vcnt_nx = (out_vcnt == VW'(V_FRAME - 1)) ?
                  '0 : out_vcnt + 1'b1;
    end
    if (w_hlead) w_hcnt_nx = HW'(H_ACTIVE + H_FRONT_PORCH);
    if (w_vlead) w_vcnt_nx = VW'(V_ACTIVE + V_FRONT_PORCH);
  end

  assign w_len_bad   = (r_line_cnt != LW'(H_FRAME));
  assign w_timeout   = (r_line_cnt == LW'(2 * H_FRAME)) && !w_hlead;
  // The edge coincident with vsync closes the ending frame.
  assign w_tally_tot = {1'b0, r_tally} + (TW + 1)'(w_hlead);
  assign w_tally_ok  = (w_tally_tot == (TW + 1)'(V_FRAME));
  assign w_frame_good = !r_bad && !(w_hlead && w_len_bad)
                     && w_tally_ok;

`ifdef VID_SYNC_TRACKER_DE_CHECK_EN
  assign w_de_bad = r_de != ((w_hcnt_nx < HW'(H_ACTIVE))
                          && (w_vcnt_nx < VW'(V_ACTIVE)));
`else
  assign w_de_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_hs         <= 1'b0;
      r_vs         <= 1'b0;
      r_hs_d       <= 1'b0;
      r_vs_d       <= 1'b0;
      r_de         <= 1'b0;
      r_data       <= '0;
      out_data     <= '0;
      out_vde      <= 1'b0;
      out_hcnt     <= '0;
      out_vcnt     <= '0;
      out_line_len <= '0;
      r_line_cnt   <= '0;
      r_tally      <= '0;
      r_bad        <= 1'b0;
    end else begin
      r_hs     <= w_hs_in;
      r_vs     <= w_vs_in;
      r_hs_d   <= r_hs;
      r_vs_d   <= r_vs;
      r_de     <= in_vde;
      r_data   <= in_data;
      out_data <= r_data;
      out_vde  <= r_de;
      out_hcnt <= w_hcnt_nx;
      out_vcnt <= w_vcnt_nx;
      if (w_hlead) begin
        r_line_cnt   <= LW'(1);
        out_line_len <= r_line_cnt;
      end else if (r_line_cnt != L_MAX) begin
        r_line_cnt <= r_line_cnt + 1'b1;
      end
      if (w_vlead) begin
        r_tally <= '0;
        r_bad   <= 1'b0;
      end else if (w_hlead) begin
        if (r_tally != T_MAX) r_tally <= r_tally + 1'b1;
        if (w_len_bad) r_bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state       <= SEARCH;
      r_good        <= '0;
      out_locked    <= 1'b0;
      out_err       <= 1'b0;
      out_frame_cnt <= '0;
    end else begin
      out_err <= 1'b0;
      case (r_state)
        SEARCH: begin
          if (w_vlead) begin
            r_state <= VERIFY;
            r_good  <= '0;
          end
        end
        VERIFY: begin
          if (w_timeout) begin
            r_state <= SEARCH;
            r_good  <= '0;
          end else if (w_vlead) begin
            if (!w_frame_good) begin
              r_good <= '0;
            end else if (r_good == GW'(LOCK_FRAMES - 1)) begin
              r_state    <= LOCKED;
              r_good     <= '0;
              out_locked <= 1'b1;
            end else begin
              r_good <= r_good + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (w_timeout) begin
            r_state    <= SEARCH;
            out_locked <= 1'b0;
            out_err    <= 1'b1;
          end else if ((w_hlead && w_len_bad) || w_de_bad
                    || (w_vlead && !w_tally_ok)) begin
            r_state    <= VERIFY;
            r_good     <= '0;
            out_locked <= 1'b0;
            out_err    <= 1'b1;
          end else if (w_vlead) begin
            out_frame_cnt <= out_frame_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= SEARCH;
          r_good     <= '0;
          out_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vid_sync_tracker.sv
// Directed bench for vid_sync_tracker: 14x7 frame, both sync polarities in parallel.
module tb_vid_sync_tracker;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        hs_p, vs_p, hs_n, vs_n, de;
  logic [23:0] din;

  logic [23:0] p_data, n_data;
  logic        p_vde, n_vde;
  logic [3:0]  p_hcnt, n_hcnt;
  logic [2:0]  p_vcnt, n_vcnt;
  logic        p_lock, n_lock;
  logic        p_err, n_err;
  logic [15:0] p_fc, n_fc;
  logic [5:0]  p_ll, n_ll;

  always #5 clk = ~clk;

  vid_sync_tracker #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(2),
    .H_BACK_PORCH(2), .V_ACTIVE(4), .V_FRONT_PORCH(1),
    .V_SYNC_WIDTH(1), .V_BACK_PORCH(1), .DATA_WIDTH(8),
    .CHANNELS(3), .LOCK_FRAMES(2), .SYNC_POL(1)
  ) dut_p (
    .clk(clk), .n_rst(n_rst),
    .in_hsync(hs_p), .in_vsync(vs_p), .in_vde(de),
    .in_data(din), .out_data(p_data), .out_vde(p_vde),
    .out_hcnt(p_hcnt), .out_vcnt(p_vcnt),
    .out_locked(p_lock), .out_err(p_err),
    .out_frame_cnt(p_fc), .out_line_len(p_ll)
  );

  vid_sync_tracker #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(2),
    .H_BACK_PORCH(2), .V_ACTIVE(4), .V_FRONT_PORCH(1),
    .V_SYNC_WIDTH(1), .V_BACK_PORCH(1), .DATA_WIDTH(8),
    .CHANNELS(3), .LOCK_FRAMES(2), .SYNC_POL(0)
  ) dut_n (
    .clk(clk), .n_rst(n_rst),
    .in_hsync(hs_n), .in_vsync(vs_n), .in_vde(de),
    .in_data(din), .out_data(n_data), .out_vde(n_vde),
    .out_hcnt(n_hcnt), .out_vcnt(n_vcnt),
    .out_locked(n_lock), .out_err(n_err),
    .out_frame_cnt(n_fc), .out_line_len(n_ll)
  );

  int checks = 0;
  int failures = 0;

  // Generator position and the pixel now visible at the outputs.
  int ph = 10, pv = 5;
  int oh = -1, ov = -1;
  bit first, skip, hmask, de_force, mis;
  bit lvalid = 1'b0;
  bit lmis;
  int lh, lv;
  logic [23:0] ld;
  logic lde;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    chk({tag, "_pol1"}, a, exp);
    chk({tag, "_pol0"}, b, exp);
  endtask

  task automatic step();
    logic h, v, e;
    logic [23:0] d;
    if (skip && ph == 12 && pv == 5) begin
      ph = 13;
      skip = 1'b0;
      mis = 1'b1;
    end
    if (ph == 10) mis = 1'b0;
    h = (ph == 10 || ph == 11) && !(hmask && (pv == 1 || pv == 2));
    v = (pv == 5 && ph >= 10) || (pv == 6 && ph < 10);
    e = (ph < 8 && pv < 4) || (de_force && ph == 9 && pv == 1);
    d = first ? 24'hABCDEF : 24'($urandom());
    hs_p = h; vs_p = v;
    hs_n = ~h; vs_n = ~v;
    de = e; din = d;
    @(posedge clk);
    #1;
    if (lvalid) begin
      chk2("data", p_data, n_data, ld);
      chk2("vde", p_vde, n_vde, lde);
      if (!lmis) begin
        chk2("hcnt", p_hcnt, n_hcnt, lh);
        chk2("vcnt", p_vcnt, n_vcnt, lv);
      end
    end
    oh = lvalid ? lh : -1;
    ov = lvalid ? lv : -1;
    lvalid = 1'b1;
    lh = ph; lv = pv; ld = d; lde = e; lmis = mis;
    ph++;
    if (ph == 14) begin
      ph = 0;
      pv = (pv == 6) ? 0 : pv + 1;
    end
  endtask

  task automatic show(input int h, input int v, input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < 2000) begin
      step();
      budget++;
      if (oh == h && ov == v) seen++;
    end
    checks++;
    if (seen < n) begin
      failures++;
      $error("FAIL show_timeout observed=%0d expected=%0d", seen, n);
    end
  endtask

  initial begin
    hs_p = 1'b0; vs_p = 1'b0; hs_n = 1'b1; vs_n = 1'b1;
    de = 1'b0; din = '0;
    first = 0; skip = 0; hmask = 0; de_force = 0; mis = 0;
    repeat (3) @(posedge clk);
    #1;
    chk2("rst_data", p_data, n_data, 0);
    chk2("rst_vde", p_vde, n_vde, 0);
    chk2("rst_hcnt", p_hcnt, n_hcnt, 0);
    chk2("rst_vcnt", p_vcnt, n_vcnt, 0);
    chk2("rst_lock", p_lock, n_lock, 0);
    chk2("rst_err", p_err, n_err, 0);
    chk2("rst_fc", p_fc, n_fc, 0);
    chk2("rst_ll", p_ll, n_ll, 0);

    n_rst = 1'b1;
    first = 1'b1;
    step();
    first = 1'b0;
    step();
    chk2("first_data", p_data, n_data, 24'hABCDEF);
    chk2("first_hcnt", p_hcnt, n_hcnt, 10);
    chk2("first_vcnt", p_vcnt, n_vcnt, 5);
    repeat (4) step();
    chk2("wrap_hcnt", p_hcnt, n_hcnt, 0);
    chk2("wrap_vcnt", p_vcnt, n_vcnt, 6);

    show(9, 5, 2);
    chk2("prelock", p_lock, n_lock, 0);
    step();
    chk2("lock_rise", p_lock, n_lock, 1);
    chk2("lock_err", p_err, n_err, 0);
    chk2("lock_fc", p_fc, n_fc, 0);
    chk2("line_len", p_ll, n_ll, 14);
    show(9, 5, 1);
    chk2("fc_before", p_fc, n_fc, 0);
    step();
    chk2("fc_after", p_fc, n_fc, 1);
    chk2("still_lock", p_lock, n_lock, 1);

    skip = 1'b1;
    show(9, 6, 1);
    chk2("short_pre_err", p_err, n_err, 0);
    chk2("short_pre_lock", p_lock, n_lock, 1);
    step();
    chk2("short_err", p_err, n_err, 1);
    chk2("short_lock", p_lock, n_lock, 0);
    chk2("short_len", p_ll, n_ll, 13);
    step();
    chk2("short_err_end", p_err, n_err, 0);
    chk2("short_fc", p_fc, n_fc, 1);
    show(9, 5, 3);
    chk2("relock_pre", p_lock, n_lock, 0);
    step();
    chk2("relock", p_lock, n_lock, 1);

    hmask = 1'b1;
    show(9, 2, 1);
    chk2("to_pre_err", p_err, n_err, 0);
    chk2("to_pre_lock", p_lock, n_lock, 1);
    step();
    chk2("to_err", p_err, n_err, 1);
    chk2("to_lock", p_lock, n_lock, 0);
    step();
    chk2("to_err_end", p_err, n_err, 0);
    hmask = 1'b0;
    show(10, 3, 1);
    chk2("to_len", p_ll, n_ll, 42);
    show(9, 5, 3);
    chk2("to_relock_pre", p_lock, n_lock, 0);
    step();
    chk2("to_relock", p_lock, n_lock, 1);
    chk2("to_fc", p_fc, n_fc, 1);

    de_force = 1'b1;
    show(8, 1, 1);
    chk2("de_pre_err", p_err, n_err, 0);
    step();
`ifdef VID_SYNC_TRACKER_DE_CHECK_EN
    chk2("de_err", p_err, n_err, 1);
    chk2("de_lock", p_lock, n_lock, 0);
`else
    chk2("de_err", p_err, n_err, 0);
    chk2("de_lock", p_lock, n_lock, 1);
    chk2("de_vde", p_vde, n_vde, 1);
`endif
    step();
    chk2("de_err_end", p_err, n_err, 0);
    de_force = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
